c17_response_analyzer: RTL and testbench
========================================

# c17_response_analyzer

Downstream response analyzer for the approximate c17 test circuit. Accepts each applied 5-bit stimulus together with the circuit's two outputs. Recomputes the exact c17 response internally and counts per-output mismatches over a run of NUM_PATTERNS vectors. Optionally compacts the observed outputs into a MISR signature so that approximate variants can be characterised in the characterisation flow.

## Interface
Parameters:
- NUM_PATTERNS, 32: accepted samples per run, minimum 1.
- CNT_W, 16: width of each error counter.
- MISR_POLY, 16'hB400: feedback taps of the 16-bit MISR.

Ports:
- CLK  in  1  clock; everything is rising-edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run.
- in_valid  in  1  stimulus/response pair present this cycle.
- in_ready  out  1  analyzer accepts a sample.
- in_vec  in  5  applied stimulus; [4]=IN_a, [3]=IN_b, [2]=IN_c, [1]=IN_d, [0]=IN_e.
- dut_out  in  2  circuit response; [1]=OUT_a, [0]=OUT_b.
- busy  out  1  run in progress.
- done  out  1  results valid.
- err_a  out  CNT_W  mismatches on OUT_a.
- err_b  out  CNT_W  mismatches on OUT_b.
- err_any  out  CNT_W  samples with at least one mismatch.
- signature  out  16  MISR contents.

## Operation
- Exact reference, with g = in_vec fields a..e:
  - n10 = ~(a&c)
  - n11 = ~(c&d)
  - n16 = ~(b&n11)
  - n19 = ~(n11&e)
  - gold_a = ~(n10&n16)
  - gold_b = ~(n16&n19)
- FSM states are IDLE, RUN and DONE.
  - IDLE: start moves to RUN and clears all counters, the pattern count and the signature.
  - RUN: a sample is accepted when in_valid && in_ready. On the accepted sample with pattern count == NUM_PATTERNS-1, the FSM moves to DONE. start is ignored in RUN.
  - DONE: results are held. start moves to RUN with a clear, so a new run begins.
- in_ready = (state == RUN). busy = (state == RUN). done = (state == DONE).
- Per accepted sample:
  - err_a increments when dut_out[1] != gold_a.
  - err_b increments when dut_out[0] != gold_b.
  - err_any increments when either output mismatches.
  - All error counters saturate at all-ones and never wrap.
- Pattern count width is $clog2(NUM_PATTERNS+1).
- MISR update per accepted sample: sig <= {sig[14:0],1'b0} ^ (sig[15] ? MISR_POLY : 0) ^ {14'b0, dut_out}.
- in_valid is ignored outside RUN. Samples presented outside RUN are not counted.

## Timing
- Reset values: state IDLE; in_ready, busy and done are 0; err_a, err_b and err_any are 0; signature is 16'h0000.
- start at edge k puts the FSM in RUN at edge k. in_ready is 1 from cycle k+1.
- Every counter and the signature update at the edge on which their sample is accepted. Latency is 1 cycle.
- done rises at the edge that accepts the final sample. in_ready is 0 in the following cycle.
- Reset asserted mid-run returns the block to the reset state immediately. Partial results are lost.
- Gaps in in_valid stall the run with no timeout.

## Configuration
- C17_MISR_EN defined: the MISR is built as described above.
- C17_MISR_EN undefined: no MISR flops are built and signature is tied to 16'h0000. Error counting and the FSM are unchanged.

## Structure
- Shared package c17_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the default MISR polynomial constant;
  - field index constants for in_vec and dut_out.
- Sub-module c17_golden is a purely combinational exact c17 (in_vec in, {gold_a,gold_b} out). It is reused by other approximate-variant benches.

## Test plan
- Reset, then no start, with in_valid held high for 40 cycles: all outputs stay at reset values and done stays 0.
- start, then 32 vectors 0..31 with dut_out equal to the golden value each cycle: done is 1 after the 32nd acceptance, err_a = err_b = err_any = 0.
- Same 32 vectors with dut_out = ~golden: err_a = 32, err_b = 32, err_any = 32.
- in_vec = 5'b00000 with dut_out = 2'b01 (golden is 00), then in_vec = 5'b11111 with dut_out = 2'b10 (golden is 10): err_b = 1, err_a = 0, err_any = 1.
- With C17_MISR_EN, first accepted sample has dut_out = 2'b11: signature = 16'h0003. Without the macro, signature = 16'h0000.
- Assert RST after 10 accepted samples: outputs clear. A new start then begins counting from 0. A start pulse during RUN does not reset the counts.

Source files
------------

// File: rtl/c17_pkg.sv
// Shared types and constants for the c17 response analyzer.
// Holds the FSM state enum, the default MISR polynomial and field indices.
package c17_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [15:0] MISR_POLY_DEFAULT = 16'hB400;

   localparam int IN_A = 4;
   localparam int IN_B = 3;
   localparam int IN_C = 2;
   localparam int IN_D = 1;
   localparam int IN_E = 0;

   localparam int OUT_A = 1;
   localparam int OUT_B = 0;

endpackage

// File: rtl/c17_golden.sv
// Exact combinational c17 reference: six NAND gates.
// gold_o[OUT_A] = gold_a, gold_o[OUT_B] = gold_b.
module c17_golden
   import c17_pkg::*;
(
   input  logic [4:0] in_vec_i,
   output logic [1:0] gold_o
);

   logic n10;
   logic n11;
   logic n16;
   logic n19;

   assign n10 = ~(in_vec_i[IN_A] & in_vec_i[IN_C]);
   assign n11 = ~(in_vec_i[IN_C] & in_vec_i[IN_D]);
   assign n16 = ~(in_vec_i[IN_B] & n11);
   assign n19 = ~(n11 & in_vec_i[IN_E]);

   assign gold_o[OUT_A] = ~(n10 & n16);
   assign gold_o[OUT_B] = ~(n16 & n19);

endmodule

// File: rtl/c17_response_analyzer.sv
// Counts per-output mismatches of a c17 variant against the exact circuit.
// Define C17_MISR_EN to build the 16-bit MISR signature compactor.
module c17_response_analyzer
   import c17_pkg::*;
#(
   parameter int          NUM_PATTERNS = 32,
   parameter int          CNT_W        = 16,
   parameter logic [15:0] MISR_POLY    = MISR_POLY_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_vec,
   input  logic [1:0]       dut_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_a,
   output logic [CNT_W-1:0] err_b,
   output logic [CNT_W-1:0] err_any,
   output logic [15:0]      signature
);

   localparam int PC_W = $clog2(NUM_PATTERNS + 1);
   localparam logic [PC_W-1:0] LAST_CNT = PC_W'(NUM_PATTERNS - 1);

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pcnt_q, pcnt_d;
   logic [CNT_W-1:0] err_a_q, err_a_d;
   logic [CNT_W-1:0] err_b_q, err_b_d;
   logic [CNT_W-1:0] err_any_q, err_any_d;
   logic [1:0]       gold;
   logic             acc;
   logic             clr;
   logic             last;
   logic             mis_a;
   logic             mis_b;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   c17_golden u_golden (
      .in_vec_i (in_vec),
      .gold_o   (gold)
   );

   assign acc   = in_valid && (state_q == RUN);
   assign clr   = start && (state_q != RUN);
   assign last  = acc && (pcnt_q == LAST_CNT);
   assign mis_a = dut_out[OUT_A] != gold[OUT_A];
   assign mis_b = dut_out[OUT_B] != gold[OUT_B];

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state: start is only honoured outside RUN
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Next values of pattern and error counters
   always_comb begin
      pcnt_d    = pcnt_q;
      err_a_d   = err_a_q;
      err_b_d   = err_b_q;
      err_any_d = err_any_q;
      if (clr) begin
         pcnt_d    = '0;
         err_a_d   = '0;
         err_b_d   = '0;
         err_any_d = '0;
      end else if (acc) begin
         pcnt_d = pcnt_q + 1'b1;
         if (mis_a)         err_a_d   = sat_inc(err_a_q);
         if (mis_b)         err_b_d   = sat_inc(err_b_q);
         if (mis_a | mis_b) err_any_d = sat_inc(err_any_q);
      end
   end

   // Counter registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pcnt_q    <= '0;
         err_a_q   <= '0;
         err_b_q   <= '0;
         err_any_q <= '0;
      end else begin
         pcnt_q    <= pcnt_d;
         err_a_q   <= err_a_d;
         err_b_q   <= err_b_d;
         err_any_q <= err_any_d;
      end
   end

   assign err_a   = err_a_q;
   assign err_b   = err_b_q;
   assign err_any = err_any_q;

`ifdef C17_MISR_EN
   logic [15:0] sig_q, sig_d;

   // MISR next value: shift, polynomial feedback, inject observed outputs
   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (acc) begin
         sig_d = {sig_q[14:0], 1'b0}
               ^ (sig_q[15] ? MISR_POLY : 16'h0000)
               ^ {14'b0, dut_out};
      end
   end

   // MISR register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sig_q <= '0;
      else     sig_q <= sig_d;
   end

   assign signature = sig_q;
`else
   // No compactor: constant zero that still references the polynomial
   assign signature = MISR_POLY & 16'h0000;
`endif

endmodule

// File: tb/tb_c17_response_analyzer.sv
// Randomized scoreboard bench for c17_response_analyzer.
// Expected run results are queued at stimulus time and checked when done rises.
module tb_c17_response_analyzer;

   localparam int NUM = 32;
   localparam int CW  = 16;
   localparam logic [15:0] POLY = 16'hB400;

   typedef struct {
      int          ea;
      int          eb;
      int          eany;
      logic [15:0] sig;
   } exp_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [4:0]    in_vec = '0;
   logic [1:0]    dut_out = '0;
   logic          busy;
   logic          done;
   logic [CW-1:0] err_a;
   logic [CW-1:0] err_b;
   logic [CW-1:0] err_any;
   logic [15:0]   signature;

   int checks = 0;
   int errors = 0;

   exp_t sb[$];

   int          m_ea;
   int          m_eb;
   int          m_eany;
   int          m_cnt;
   logic [15:0] m_sig;

   logic done_prev = 1'b0;

   c17_response_analyzer #(
      .NUM_PATTERNS (NUM),
      .CNT_W        (CW),
      .MISR_POLY    (POLY)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .dut_out   (dut_out),
      .busy      (busy),
      .done      (done),
      .err_a     (err_a),
      .err_b     (err_b),
      .err_any   (err_any),
      .signature (signature)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sum-of-products form of c17: a NAND-NAND network flattened by hand.
   function automatic logic [1:0] ref_gold(input logic [4:0] v);
      bit a, b, c, d, e, nd, ga, gb;
      a = v[4]; b = v[3]; c = v[2]; d = v[1]; e = v[0];
      nd = !(c && d);
      ga = (a && c) || (b && nd);
      gb = nd && (b || e);
      return {ga, gb};
   endfunction

   function automatic int sat(input int v);
      int mx;
      mx = (1 << CW) - 1;
      return (v + 1 > mx) ? mx : v + 1;
   endfunction

   task automatic model_clear();
      m_ea = 0; m_eb = 0; m_eany = 0; m_cnt = 0; m_sig = '0;
   endtask

   task automatic model_accept(input logic [4:0] v, input logic [1:0] o);
      logic [1:0] g;
      exp_t e;
      g = ref_gold(v);
      if (o[1] != g[1]) m_ea = sat(m_ea);
      if (o[0] != g[0]) m_eb = sat(m_eb);
      if (o != g)       m_eany = sat(m_eany);
`ifdef C17_MISR_EN
      m_sig = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? POLY : 16'h0) ^ {14'b0, o};
`endif
      m_cnt++;
      if (m_cnt == NUM) begin
         e.ea = m_ea; e.eb = m_eb; e.eany = m_eany; e.sig = m_sig;
         sb.push_back(e);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      model_clear();
   endtask

   task automatic send(input logic [4:0] v, input logic [1:0] o);
      int gaps;
      in_vec = v; dut_out = o; in_valid = 1'b1;
      @(posedge CLK);
      model_accept(v, o);
      #1 in_valid = 1'b0;
      in_vec = 5'($urandom); dut_out = 2'($urandom);
      gaps = $urandom_range(0, 2);
      if (m_cnt < NUM) repeat (gaps) begin
         @(posedge CLK);
         #1;
      end
   endtask

   function automatic logic [1:0] rand_out(input logic [4:0] v);
      logic [1:0] m;
      m = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      return ref_gold(v) ^ m;
   endfunction

   task automatic rand_samples(input int n);
      logic [4:0] v;
      for (int i = 0; i < n; i++) begin
         v = 5'($urandom);
         send(v, rand_out(v));
      end
   endtask

   task automatic finish_run();
      @(negedge CLK);
      chk("done_after_run", done, 1'b1);
   endtask

   // Monitor: on each rising done, pop the expected result and compare
   always @(negedge CLK) begin
      exp_t e;
      if (!RST && done && !done_prev) begin
         if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk("mon_err_a", err_a, e.ea);
            chk("mon_err_b", err_b, e.eb);
            chk("mon_err_any", err_any, e.eany);
            chk("mon_sig", signature, e.sig);
            chk("mon_ready_low", in_ready, 1'b0);
            chk("mon_busy_low", busy, 1'b0);
         end
      end
      done_prev = done;
   end

   initial begin
      logic [4:0] v;
      model_clear();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err_a", err_a, 0);
      chk("rst_err_b", err_b, 0);
      chk("rst_err_any", err_any, 0);
      chk("rst_sig", signature, 16'h0);
      @(posedge CLK);
      #1 RST = 1'b0;

      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in_vec = 5'($urandom); dut_out = 2'($urandom);
         @(negedge CLK);
         chk("idle_done", done, 1'b0);
      end
      chk("idle_err_any", err_any, 0);
      chk("idle_sig", signature, 16'h0);
      chk("idle_busy", busy, 1'b0);
      @(posedge CLK);
      #1 in_valid = 1'b0;

      do_start();
      for (int i = 0; i < NUM; i++) begin
         v = 5'(i);
         send(v, ref_gold(v));
      end
      finish_run();

      do_start();
      for (int i = 0; i < NUM; i++) begin
         v = 5'(i);
         send(v, ~ref_gold(v));
      end
      finish_run();
      chk("inv_err_a", err_a, 32);
      chk("inv_err_b", err_b, 32);
      chk("inv_err_any", err_any, 32);

      do_start();
      send(5'b00000, 2'b01);
      send(5'b11111, 2'b10);
      @(negedge CLK);
      chk("pair_err_a", err_a, 0);
      chk("pair_err_b", err_b, 1);
      chk("pair_err_any", err_any, 1);
      rand_samples(NUM - 2);
      finish_run();

      do_start();
      send(5'($urandom), 2'b11);
      @(negedge CLK);
`ifdef C17_MISR_EN
      chk("first_sig", signature, 16'h0003);
`else
      chk("first_sig", signature, 16'h0000);
`endif
      rand_samples(NUM - 1);
      finish_run();

      do_start();
      rand_samples(10);
      @(negedge CLK);
      chk("mid_err_a", err_a, m_ea);
      chk("mid_err_any", err_any, m_eany);
      @(posedge CLK);
      #1 start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      @(negedge CLK);
      chk("start_in_run_busy", busy, 1'b1);
      chk("start_in_run_err_b", err_b, m_eb);
      chk("start_in_run_sig", signature, m_sig);
      @(posedge CLK);
      #2 RST = 1'b1;
      @(negedge CLK);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_ready", in_ready, 1'b0);
      chk("mrst_err_a", err_a, 0);
      chk("mrst_err_b", err_b, 0);
      chk("mrst_err_any", err_any, 0);
      chk("mrst_sig", signature, 16'h0);
      @(posedge CLK);
      #1 RST = 1'b0;

      do_start();
      rand_samples(NUM);
      finish_run();

      for (int r = 0; r < 3; r++) begin
         do_start();
         rand_samples(NUM);
         finish_run();
      end

      repeat (2) @(negedge CLK);
      chk("sb_drained", sb.size(), 0);
      chk("final_done", done, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
